cam_match_array: RTL and testbench
==================================

// Module: cam_match_array
// PURPOSE
//   Binary content-addressable memory: DEPTH entries of WIDTH bits.
//   Each bit cell stores one bit and compares it with the search bit; bit match = XNOR(stored, search).
//   Entry match = valid AND all bit matches.
//   Sits between the lookup datapath and the tag/result tables; outputs a match vector plus a priority-encoded hit index.
// PARAMETERS
//   WIDTH   8    bits per entry (search key width)
//   DEPTH   16   number of entries; power of two, >= 2
//   AW      $clog2(DEPTH), localparam, entry address width
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   wr_en      in   1      write strobe (word line)
//   wr_addr    in   AW     entry to write
//   wr_data    in   WIDTH  data to store (data line)
//   wr_data_b  in   WIDTH  complement data line; write committed only if wr_data_b == ~wr_data
//   inv_en     in   1      invalidate strobe
//   inv_addr   in   AW     entry to invalidate
//   srch_en    in   1      search strobe
//   srch_data  in   WIDTH  search key (CAM data)
//   srch_mask  in   WIDTH  per-bit compare enable; 0 = don't-care bit
//   match_vec  out  DEPTH  per-entry match result, registered
//   hit        out  1      OR of match_vec, registered
//   hit_idx    out  AW     lowest matching entry index; 0 when hit=0
//   srch_vld   out  1      result-valid pulse, one cycle after srch_en
//   wr_err     out  1      pulses 1 cycle when wr_en with wr_data_b != ~wr_data
// BEHAVIOUR
//   - Reset (async assert, sync release on clk): all stored bits 0, all valid 0.
//     match_vec=0, hit=0, hit_idx=0, srch_vld=0, wr_err=0.
//   - Write: wr_en and rails complementary -> mem[wr_addr]<=wr_data, valid[wr_addr]<=1 at edge.
//     Rails not complementary -> no state change, wr_err=1 next cycle.
//   - Invalidate: inv_en -> valid[inv_addr]<=0; stored data kept.
//     inv_en and legal wr_en to same address in one cycle: write wins (entry valid).
//   - Search: combinational compare of srch_data against current (pre-edge) contents; registered at edge.
//     Latency 1 cycle: srch_vld=1, with match_vec/hit/hit_idx valid in the cycle after srch_en.
//     match_vec[i] = valid[i] & &(~(mem[i]^srch_data) | ~srch_mask).
//     srch_mask all-zero -> every valid entry matches.
//   - Search and write to same entry in one cycle: search sees old contents; new data visible from the next search.
//   - srch_en=0: match_vec/hit/hit_idx hold previous values; srch_vld=0.
//   - hit_idx: priority encoder, lowest index wins.
//   - Back-to-back searches every cycle supported; no stall, no handshake back-pressure.
//   - Reset mid-operation: pending result dropped; srch_vld=0 immediately on rst_n low.
// TESTING
//   1 Reset: rst_n=0 -> all outputs 0. Search 0x00 after release -> hit=0 (no valid entries).
//   2 Write entry 3 =0xA5 (wr_data_b=0x5A); search 0xA5 mask 0xFF
//     -> match_vec=0x0008, hit=1, hit_idx=3, srch_vld=1 one cycle later.
//   3 Bit-cell truth table: store 0/1 in bit0 of entry 0; search bit0=0/1 with mask 0x01
//     -> match only when equal (XNOR: 00=1, 01=0, 10=0, 11=1).
//   4 Entries 2 and 9 both 0x3C; search 0x3C -> match_vec=0x0204, hit_idx=2.
//     Then invalidate 2 and search again -> match_vec=0x0200, hit_idx=9.
//   5 Write entry 5 =0x11 while searching 0x11 in the same cycle -> miss;
//     next-cycle search 0x11 -> hit_idx=5. Search 0x1F mask 0xF0 -> entry 5 matches.
//   6 wr_en with wr_data=0x0F, wr_data_b=0x0F -> wr_err=1, entry unchanged.
//     Assert rst_n low mid-search -> srch_vld, hit drop to 0 asynchronously.

Source files
------------

// File: rtl/cam_match_array.sv
// Binary CAM: DEPTH entries of WIDTH bits with per-bit masked compare,
// registered match vector, hit flag and lowest-index priority encode.
module cam_match_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_data_b,
    input  logic             inv_en,
    input  logic [AW-1:0]    inv_addr,
    input  logic             srch_en,
    input  logic [WIDTH-1:0] srch_data,
    input  logic [WIDTH-1:0] srch_mask,
    output logic [DEPTH-1:0] match_vec,
    output logic             hit,
    output logic [AW-1:0]    hit_idx,
    output logic             srch_vld,
    output logic             wr_err
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] match_nxt;
    logic [AW-1:0]    idx_nxt;
    logic             wr_legal;

    // A write only commits when the two data rails are true complements.
    assign wr_legal = (wr_data_b == ~wr_data);

    always_comb begin
        match_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_nxt[i] = valid[i] & (&(~(mem[i] ^ srch_data) | ~srch_mask));
        end
    end

    // Scan from the top down so the lowest matching index is assigned last.
    always_comb begin
        idx_nxt = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_nxt[i]) begin
                idx_nxt = AW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
        end else begin
            if (inv_en) begin
                valid[inv_addr] <= 1'b0;
            end
            if (wr_en && wr_legal) begin
                mem[wr_addr]   <= wr_data;
                valid[wr_addr] <= 1'b1;
            end
        end
    end

    // Results hold between searches; srch_vld marks the cycle they refresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_vec <= '0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            srch_vld  <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            srch_vld <= srch_en;
            wr_err   <= wr_en & ~wr_legal;
            if (srch_en) begin
                match_vec <= match_nxt;
                hit       <= |match_nxt;
                hit_idx   <= idx_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cam_match_array.sv
// Self-checking bench for cam_match_array: directed scenarios followed by
// randomized traffic compared against an array-based reference model.
module tb_cam_match_array;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] wr_data_b = '0;
    logic             inv_en = 1'b0;
    logic [AW-1:0]    inv_addr = '0;
    logic             srch_en = 1'b0;
    logic [WIDTH-1:0] srch_data = '0;
    logic [WIDTH-1:0] srch_mask = '0;
    logic [DEPTH-1:0] match_vec;
    logic             hit;
    logic [AW-1:0]    hit_idx;
    logic             srch_vld;
    logic             wr_err;

    cam_match_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_data_b(wr_data_b),
        .inv_en(inv_en), .inv_addr(inv_addr),
        .srch_en(srch_en), .srch_data(srch_data), .srch_mask(srch_mask),
        .match_vec(match_vec), .hit(hit), .hit_idx(hit_idx),
        .srch_vld(srch_vld), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_mem [DEPTH];
    logic             model_valid [DEPTH];
    logic [DEPTH-1:0] exp_vec = '0;
    logic             exp_hit = 1'b0;
    logic [AW-1:0]    exp_idx = '0;
    logic             exp_vld = 1'b0;
    logic             exp_err = 1'b0;

    // An entry matches when it is valid and differs from the key only in masked-off bits.
    function automatic logic [DEPTH-1:0] model_match(logic [WIDTH-1:0] key, logic [WIDTH-1:0] mask);
        logic [DEPTH-1:0] r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (model_valid[i] && (((model_mem[i] ^ key) & mask) == 0)) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] model_lowest(logic [DEPTH-1:0] v);
        for (int i = 0; i < DEPTH; i++) begin
            if (v[i]) return AW'(i);
        end
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = '0;
            model_valid[i] = 1'b0;
        end
        exp_vec = '0; exp_hit = 1'b0; exp_idx = '0; exp_vld = 1'b0; exp_err = 1'b0;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".match_vec"}, 32'(match_vec), 32'(exp_vec));
        checkVal({tag, ".hit"},       32'(hit),       32'(exp_hit));
        checkVal({tag, ".hit_idx"},   32'(hit_idx),   32'(exp_idx));
        checkVal({tag, ".srch_vld"},  32'(srch_vld),  32'(exp_vld));
        checkVal({tag, ".wr_err"},    32'(wr_err),    32'(exp_err));
    endtask

    // Drives one cycle of inputs, predicts from pre-edge model state, then advances the model.
    task automatic applyStimulus(
        input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] wdb,
        input logic ie, input logic [AW-1:0] ia,
        input logic se, input logic [WIDTH-1:0] sd, input logic [WIDTH-1:0] sm);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_data_b = wdb;
        inv_en = ie; inv_addr = ia;
        srch_en = se; srch_data = sd; srch_mask = sm;
        if (se) begin
            exp_vec = model_match(sd, sm);
            exp_hit = (exp_vec != 0);
            exp_idx = model_lowest(exp_vec);
        end
        exp_vld = se;
        exp_err = we && (wdb != ~wd);
        if (ie) model_valid[ia] = 1'b0;
        if (we && (wdb == ~wd)) begin
            model_mem[wa]   = wd;
            model_valid[wa] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        applyStimulus(1'b1, a, d, ~d, 1'b0, '0, 1'b0, '0, '0);
        checkOutput("write");
    endtask

    task automatic do_search(input string tag, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, d, m);
        checkOutput(tag);
    endtask

    initial begin
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;
        logic [WIDTH-1:0] rm;
        logic             rwe;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset");
        rst_n = 1'b1;
        do_search("empty", 8'h00, 8'hFF);
        checkVal("empty_hit", 32'(hit), 32'd0);

        do_write(4'd3, 8'hA5);
        do_search("basic", 8'hA5, 8'hFF);
        checkVal("basic_vec", 32'(match_vec), 32'h0008);
        checkVal("basic_idx", 32'(hit_idx), 32'd3);
        checkVal("basic_vld", 32'(srch_vld), 32'd1);

        do_write(4'd0, 8'h00);
        do_search("xnor00", 8'h00, 8'h01);
        checkVal("xnor00_bit", 32'(match_vec[0]), 32'd1);
        do_search("xnor01", 8'h01, 8'h01);
        checkVal("xnor01_bit", 32'(match_vec[0]), 32'd0);
        do_write(4'd0, 8'h01);
        do_search("xnor10", 8'h00, 8'h01);
        checkVal("xnor10_bit", 32'(match_vec[0]), 32'd0);
        do_search("xnor11", 8'h01, 8'h01);
        checkVal("xnor11_bit", 32'(match_vec[0]), 32'd1);

        do_write(4'd2, 8'h3C);
        do_write(4'd9, 8'h3C);
        do_search("dual", 8'h3C, 8'hFF);
        checkVal("dual_vec", 32'(match_vec), 32'h0204);
        checkVal("dual_idx", 32'(hit_idx), 32'd2);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0, '0, '0);
        checkOutput("inv");
        do_search("after_inv", 8'h3C, 8'hFF);
        checkVal("after_inv_vec", 32'(match_vec), 32'h0200);
        checkVal("after_inv_idx", 32'(hit_idx), 32'd9);

        applyStimulus(1'b1, 4'd5, 8'h11, 8'hEE, 1'b0, '0, 1'b1, 8'h11, 8'hFF);
        checkOutput("wr_srch");
        checkVal("wr_srch_hit", 32'(hit), 32'd0);
        do_search("new_data", 8'h11, 8'hFF);
        checkVal("new_data_idx", 32'(hit_idx), 32'd5);
        do_search("masked", 8'h1F, 8'hF0);
        checkVal("masked_bit5", 32'(match_vec[5]), 32'd1);

        applyStimulus(1'b1, 4'd5, 8'h0F, 8'h0F, 1'b0, '0, 1'b0, '0, '0);
        checkOutput("bad_rails");
        checkVal("bad_rails_err", 32'(wr_err), 32'd1);
        do_search("unchanged", 8'h11, 8'hFF);
        checkVal("unchanged_idx", 32'(hit_idx), 32'd5);

        applyStimulus(1'b1, 4'd4, 8'h44, 8'hBB, 1'b1, 4'd4, 1'b0, '0, '0);
        checkOutput("wr_inv_same");
        do_search("write_wins", 8'h44, 8'hFF);
        checkVal("write_wins_bit4", 32'(match_vec[4]), 32'd1);

        for (int n = 0; n < 300; n++) begin
            ra  = AW'($urandom_range(0, DEPTH - 1));
            rd  = ($urandom_range(0, 1) == 1) ? model_mem[ra] : WIDTH'($urandom);
            rm  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : 8'hFF;
            rwe = ($urandom_range(0, 2) == 0);
            applyStimulus(rwe, AW'($urandom), WIDTH'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : ~WIDTH'(0),
                          ($urandom_range(0, 5) == 0), AW'($urandom),
                          ($urandom_range(0, 3) != 0), rd, rm);
            checkOutput("random");
        end

        do_write(4'd7, 8'h77);
        do_search("pre_reset", 8'h77, 8'hFF);
        checkVal("pre_reset_vld", 32'(srch_vld), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("async_reset");
        checkVal("async_reset_hit", 32'(hit), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
